// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - IF stage of a 5-stage MIPS32 pipeline
//
// Purpose:
//   Holds the program counter and presents it as the instruction memory
//   address. The memory answers in the same cycle. The returned word and
//   PC+4 are captured into the IF/ID pipeline register. The hazard unit
//   can stall the stage. A branch or jump resolved in ID can redirect it.
//
// Ports:
//   clk             in   1   system clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   stall           in   1   hold PC, IF/ID and fetch_count
//   redirect_valid  in   1   load redirect_pc and squash IF/ID (beats stall)
//   redirect_pc     in   32  redirect target byte address (aligned on load)
//   imem_addr       out  32  byte address to instruction memory (== pc)
//   imem_instr      in   32  instruction word for imem_addr, same cycle
//   if_id_instr     out  32  IF/ID instruction register
//   if_id_pc4       out  32  IF/ID PC+4 register
//   if_id_valid     out  1   IF/ID holds a real (non-squashed) instruction
//   redirect_misal  out  1   one-cycle pulse: last redirect target was misaligned
//   fetch_count     out  32  instructions delivered to ID (modulo 2^32)

module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        redirect_misal,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // This addition is 32-bit modulo, so 0xFFFF_FFFC wraps to 0.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // The low bits are dropped so that the pc is always word aligned,
      // even when the reset vector is misaligned.
      pc             <= {RESET_PC[31:2], 2'b00};
      if_id_instr    <= NOP_INSTR;
      if_id_pc4      <= 32'd0;
      if_id_valid    <= 1'b0;
      redirect_misal <= 1'b0;
      fetch_count    <= 32'd0;
    end else if (redirect_valid) begin
      // The word fetched this cycle is on the wrong path, so it is squashed.
      // A misaligned target is aligned here. It is only flagged, never trapped.
      pc             <= {redirect_pc[31:2], 2'b00};
      if_id_instr    <= NOP_INSTR;
      if_id_pc4      <= 32'd0;
      if_id_valid    <= 1'b0;
      redirect_misal <= |redirect_pc[1:0];
    end else if (stall) begin
      redirect_misal <= 1'b0;
    end else begin
      pc             <= pc_plus4;
      if_id_instr    <= imem_instr;
      if_id_pc4      <= pc_plus4;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
      redirect_misal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - directed self-checking bench for mips_fetch_stage

module tb_mips_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        redirect_misal;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:15];
  int errors = 0;
  int checks = 0;

  mips_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .redirect_misal (redirect_misal),
    .fetch_count    (fetch_count)
  );

  // zero-latency instruction memory, 16 words, aliased on address bits [5:2]
  assign imem_instr = mem[imem_addr[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0]  = 32'h0211_4020;
    mem[1]  = 32'h0113_4821;
    mem[2]  = 32'h0294_5022;
    mem[6]  = 32'h02D5_A004;
    mem[9]  = 32'h0123_4567;
    mem[15] = 32'hDEAD_BEEF;

    // T1: reset held while the other inputs try to move the pc
    rst = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #2 rst = 1'b1;
    step(); step(); step();
    check("t1_addr",  imem_addr, 32'h0);
    check("t1_valid", 32'(if_id_valid), 32'h0);
    check("t1_instr", if_id_instr, 32'h0);
    check("t1_pc4",   if_id_pc4, 32'h0);
    check("t1_count", fetch_count, 32'h0);
    check("t1_misal", 32'(redirect_misal), 32'h0);
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst = 1'b0;

    // T2: free run
    step();
    check("t2_e1_instr", if_id_instr, 32'h0211_4020);
    check("t2_e1_pc4",   if_id_pc4, 32'h4);
    check("t2_e1_valid", 32'(if_id_valid), 32'h1);
    check("t2_e1_addr",  imem_addr, 32'h4);
    step();
    check("t2_e2_instr", if_id_instr, 32'h0113_4821);
    check("t2_e2_pc4",   if_id_pc4, 32'h8);
    check("t2_e2_addr",  imem_addr, 32'h8);
    check("t2_e2_count", fetch_count, 32'd2);

    // T3: stall two cycles at pc=0x8
    stall = 1'b1;
    step(); step();
    check("t3_addr",  imem_addr, 32'h8);
    check("t3_instr", if_id_instr, 32'h0113_4821);
    check("t3_pc4",   if_id_pc4, 32'h8);
    check("t3_count", fetch_count, 32'd2);
    stall = 1'b0;
    step();
    check("t3_rel_instr", if_id_instr, 32'h0294_5022);
    check("t3_rel_pc4",   if_id_pc4, 32'hC);
    check("t3_rel_count", fetch_count, 32'd3);

    // T4: redirect beats stall
    redirect_valid = 1'b1; redirect_pc = 32'h18; stall = 1'b1;
    step();
    check("t4_addr",  imem_addr, 32'h18);
    check("t4_valid", 32'(if_id_valid), 32'h0);
    check("t4_instr", if_id_instr, 32'h0);
    check("t4_pc4",   if_id_pc4, 32'h0);
    check("t4_count", fetch_count, 32'd3);
    check("t4_misal", 32'(redirect_misal), 32'h0);
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    check("t4_f_instr", if_id_instr, 32'h02D5_A004);
    check("t4_f_pc4",   if_id_pc4, 32'h1C);
    check("t4_f_valid", 32'(if_id_valid), 32'h1);
    check("t4_f_count", fetch_count, 32'd4);

    // T5: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h1A;
    step();
    check("t5_addr",  imem_addr, 32'h18);
    check("t5_misal", 32'(redirect_misal), 32'h1);
    check("t5_valid", 32'(if_id_valid), 32'h0);
    redirect_valid = 1'b0;
    step();
    check("t5_misal_clr", 32'(redirect_misal), 32'h0);
    check("t5_instr",     if_id_instr, 32'h02D5_A004);
    check("t5_count",     fetch_count, 32'd5);

    // back-to-back redirects: one bubble each, pc follows the last
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_pc = 32'h24;
    step();
    check("b2b_addr",  imem_addr, 32'h24);
    check("b2b_valid", 32'(if_id_valid), 32'h0);
    check("b2b_count", fetch_count, 32'd5);
    redirect_valid = 1'b0;
    step();
    check("b2b_instr", if_id_instr, 32'h0123_4567);
    check("b2b_pc4",   if_id_pc4, 32'h28);

    // pc wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc4",  if_id_pc4, 32'h0);
    check("wrap_instr", if_id_instr, 32'hDEAD_BEEF);
    check("wrap_count", fetch_count, 32'd7);

    // T6: asynchronous reset mid-cycle
    step();
    #2 rst = 1'b1;
    #1;
    check("t6_addr",  imem_addr, 32'h0);
    check("t6_valid", 32'(if_id_valid), 32'h0);
    check("t6_count", fetch_count, 32'h0);
    check("t6_instr", if_id_instr, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("t6_f_instr", if_id_instr, 32'h0211_4020);
    check("t6_f_pc4",   if_id_pc4, 32'h4);
    check("t6_f_count", fetch_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
